// File: rtl/xkeypad_controller.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, debounces full-scan
// frames and latches one key code per press for the CPU to poll over a tiny register bus.
module xkeypad_controller #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kbd_sel,
  input  logic       addr,
  output logic [3:0] data_out,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  logic [3:0]    rows_m_q, rows_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cols_q, cols_d;
  logic          fhit_q, fhit_d;
  logic [3:0]    fcode_q, fcode_d;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [DW-1:0] dcnt_q, dcnt_d, rcnt_q, rcnt_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d, ovr_q, ovr_d;

  logic       tick, frame_end, latch;
  logic [1:0] col_idx, samp_row;
  logic       samp_hit, f_hit;
  logic [3:0] f_code;

  assign tick      = (cnt_q == CW'(SCAN_DIV - 1));
  assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
  assign cols_d    = tick ? {cols_q[2:0], cols_q[3]} : cols_q;
  assign frame_end = tick && (col_idx == 2'd3);

  always_comb begin
    case (cols_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Descending scan so the lowest pressed row is the last (winning) assignment.
  always_comb begin
    samp_row = 2'd0;
    for (int r = 3; r >= 0; r--)
      if (!rows_s_q[r]) samp_row = r[1:0];
  end
  assign samp_hit = ~&rows_s_q;

  // Column 0 starts a fresh frame; later columns only fill in if nothing hit yet.
  always_comb begin
    if (col_idx == 2'd0 || !fhit_q) begin
      f_hit  = samp_hit;
      f_code = {samp_row, col_idx};
    end else begin
      f_hit  = 1'b1;
      f_code = fcode_q;
    end
  end

  assign fhit_d  = (tick && !frame_end) ? f_hit  : fhit_q;
  assign fcode_d = (tick && !frame_end) ? f_code : fcode_q;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    dcnt_d  = dcnt_q;
    rcnt_d  = rcnt_q;
    latch   = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: if (f_hit) begin
          cand_d = f_code;
          dcnt_d = DW'(1);
          if (DEBOUNCE_FRAMES == 1) begin
            latch   = 1'b1;
            state_d = HELD;
            rcnt_d  = '0;
          end else begin
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!f_hit) begin
            state_d = IDLE;
            dcnt_d  = '0;
          end else if (f_code == cand_q) begin
            dcnt_d = (dcnt_q == DMAX) ? dcnt_q : dcnt_q + 1'b1;
            if (int'(dcnt_q) + 1 >= DEBOUNCE_FRAMES) begin
              latch   = 1'b1;
              state_d = HELD;
              rcnt_d  = '0;
            end
          end else begin
            cand_d = f_code;
            dcnt_d = DW'(1);
          end
        end
        HELD: begin
          if (f_hit) begin
            rcnt_d = '0;
          end else begin
            rcnt_d = (rcnt_q == DMAX) ? rcnt_q : rcnt_q + 1'b1;
            if (int'(rcnt_q) + 1 >= DEBOUNCE_FRAMES) begin
              state_d = IDLE;
              rcnt_d  = '0;
              dcnt_d  = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A latch on the same edge as a read takes priority over the read's clear.
  always_comb begin
    key_d   = latch ? f_code : key_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (kbd_sel && !addr) valid_d = 1'b0;
    if (kbd_sel &&  addr) ovr_d   = 1'b0;
    if (latch) begin
      valid_d = 1'b1;
      if (valid_q) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_m_q <= 4'hF;
      rows_s_q <= 4'hF;
      cnt_q    <= '0;
      cols_q   <= 4'b1110;
      fhit_q   <= 1'b0;
      fcode_q  <= '0;
      state_q  <= IDLE;
      cand_q   <= '0;
      dcnt_q   <= '0;
      rcnt_q   <= '0;
      key_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      rows_m_q <= rows;
      rows_s_q <= rows_m_q;
      cnt_q    <= cnt_d;
      cols_q   <= cols_d;
      fhit_q   <= fhit_d;
      fcode_q  <= fcode_d;
      state_q  <= state_d;
      cand_q   <= cand_d;
      dcnt_q   <= dcnt_d;
      rcnt_q   <= rcnt_d;
      key_q    <= key_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign cols      = cols_q;
  assign key_valid = valid_q;
  assign data_out  = addr ? {2'b00, ovr_q, valid_q} : key_q;

endmodule

// File: tb/tb_xkeypad_controller.sv
// Bench for xkeypad_controller: a simulated key matrix driven frame by frame, checked
// against a run-length debounce model and a register model of the CPU-visible state.
module tb_xkeypad_controller;
  localparam int SD = 4, DF = 3, FC = 4 * SD;

  logic       clk = 1'b0, rst = 1'b1, kbd_sel = 1'b0, addr = 1'b0;
  logic [3:0] data_out, rows, cols;
  logic       key_valid;
  logic [15:0] press_mask = '0;   // bit r*4+c = key at row r, column c held down
  int n_vec = 0, n_err = 0;

  bit m_held, m_valid, m_ovr;
  int m_run, m_none;
  logic [3:0] m_code, m_key;

  xkeypad_controller #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .rst(rst), .kbd_sel(kbd_sel), .addr(addr), .data_out(data_out),
    .rows(rows), .cols(cols), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Pressed switch shorts its row to the driven (low) column; pull-ups otherwise.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!cols[c] && press_mask[r*4+c]) rows[r] = 1'b0;
  end

  task automatic model_reset();
    m_held = 0; m_valid = 0; m_ovr = 0; m_run = 0; m_none = 0; m_code = '0; m_key = '0;
  endtask

  function automatic void frame_eval(input logic [15:0] mask, output bit hit, output logic [3:0] code);
    hit = 0; code = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!hit && mask[r*4+c]) begin hit = 1; code = {r[1:0], c[1:0]}; end
  endfunction

  // A key is accepted after DF identical frames while no key is held; a held key is
  // released after DF empty frames in a row.
  function automatic void model_fsm(input bit hit, input logic [3:0] code, output bit latch);
    latch = 0;
    if (m_held) begin
      if (hit) m_none = 0;
      else begin
        m_none++;
        if (m_none >= DF) begin m_held = 0; m_run = 0; end
      end
    end else if (!hit) begin
      m_run = 0;
    end else begin
      if (m_run > 0 && code == m_code) m_run++;
      else begin m_run = 1; m_code = code; end
      if (m_run >= DF) begin latch = 1; m_held = 1; m_none = 0; end
    end
  endfunction

  // One full scan frame with the given keys down, optionally a CPU read at cycle rc.
  task automatic run_frame(input logic [15:0] mask, input bit rd, input bit ra, input int rc);
    bit hit, latch, ov_n;
    logic [3:0] code, exp_cols, exp_do;
    frame_eval(mask, hit, code);
    model_fsm(hit, code, latch);
    press_mask = mask;
    for (int i = 0; i < FC; i++) begin
      if (rd && i == rc) begin kbd_sel = 1'b1; addr = ra; end
      #1;
      exp_cols = ~(4'b0001 << (i / SD));
      exp_do   = addr ? {2'b00, m_ovr, m_valid} : m_key;
      n_vec++;
      if (cols !== exp_cols || data_out !== exp_do || key_valid !== m_valid) begin
        n_err++;
        $display("FAIL scan cyc %0d: cols=%b data_out=%h key_valid=%b, required cols=%b data_out=%h key_valid=%b",
                 i, cols, data_out, key_valid, exp_cols, exp_do, m_valid);
      end
      @(posedge clk); #1;
      if (i == FC - 1 && latch) begin
        ov_n = m_valid | (m_ovr & !(rd && rc == i && ra));
        m_key = code; m_valid = 1; m_ovr = ov_n;
      end else if (rd && i == rc) begin
        if (ra) m_ovr = 0; else m_valid = 0;
      end
      kbd_sel = 1'b0; addr = 1'b0;
    end
  endtask

  task automatic clean_start();
    repeat (DF) run_frame('0, 0, 0, 0);
    run_frame('0, 1, 0, $urandom_range(0, FC - 1));
    run_frame('0, 1, 1, $urandom_range(0, FC - 1));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1; n_vec++;
    if (cols !== 4'b1110 || data_out !== 4'h0 || key_valid !== 1'b0) begin
      n_err++; $display("FAIL reset: cols=%b key=%h valid=%b, required 1110 0 0", cols, data_out, key_valid);
    end
    addr = 1'b1; #1; n_vec++;
    if (data_out !== 4'b0000) begin n_err++; $display("FAIL reset status: got %b required 0000", data_out); end
    addr = 1'b0;
    repeat (2) run_frame('0, 0, 0, 0);
  endtask

  task automatic test_press();
    clean_start();
    repeat (DF) run_frame(16'h1 << 10, 0, 0, 0);
    #1; n_vec++;
    if (key_valid !== 1'b1 || data_out !== 4'b1010) begin
      n_err++; $display("FAIL press latch: valid=%b key=%b required 1 1010", key_valid, data_out);
    end
    run_frame(16'h1 << 10, 1, 1, $urandom_range(0, FC - 2));
    run_frame(16'h1 << 10, 1, 0, $urandom_range(0, FC - 2));
    #1; n_vec++;
    if (key_valid !== 1'b0 || data_out !== 4'b1010) begin
      n_err++; $display("FAIL press read-clear: valid=%b key=%b required 0 1010", key_valid, data_out);
    end
  endtask

  task automatic test_bounce();
    logic [15:0] k;
    k = 16'h1 << 4;
    clean_start();
    run_frame(k, 0, 0, 0); run_frame('0, 0, 0, 0);
    run_frame(k, 0, 0, 0); run_frame(k, 0, 0, 0); run_frame('0, 0, 0, 0);
    #1; n_vec++;
    if (key_valid !== 1'b0) begin n_err++; $display("FAIL bounce: valid=%b required 0", key_valid); end
    repeat (DF) run_frame(k, 0, 0, 0);
    #1; n_vec++;
    if (key_valid !== 1'b1 || data_out !== 4'b0100) begin
      n_err++; $display("FAIL bounce latch: valid=%b key=%b required 1 0100", key_valid, data_out);
    end
  endtask

  task automatic test_hold();
    clean_start();
    for (int f = 0; f < 10; f++) run_frame(16'h1, f == 4, 0, 7);
    #1; n_vec++;
    if (key_valid !== 1'b0) begin n_err++; $display("FAIL hold single latch: valid=%b required 0", key_valid); end
    repeat (2) run_frame('0, 0, 0, 0);
    repeat (3) run_frame(16'h1, 0, 0, 0);
    #1; n_vec++;
    if (key_valid !== 1'b0) begin n_err++; $display("FAIL short release: valid=%b required 0", key_valid); end
    repeat (3) run_frame('0, 0, 0, 0);
    repeat (3) run_frame(16'h1, 0, 0, 0);
    #1; n_vec++;
    if (key_valid !== 1'b1 || data_out !== 4'h0) begin
      n_err++; $display("FAIL repress: valid=%b key=%h required 1 0", key_valid, data_out);
    end
  endtask

  task automatic test_overrun();
    clean_start();
    repeat (DF) run_frame(16'h1 << 5, 0, 0, 0);
    repeat (DF) run_frame('0, 0, 0, 0);
    repeat (DF) run_frame(16'h1 << 9, 0, 0, 0);
    addr = 1'b0; #1; n_vec++;
    if (data_out !== 4'h9) begin n_err++; $display("FAIL overrun key: got %h required 9", data_out); end
    addr = 1'b1; #1; n_vec++;
    if (data_out !== 4'b0011) begin n_err++; $display("FAIL overrun status: got %b required 0011", data_out); end
    addr = 1'b0;
    run_frame('0, 1, 1, 3);
    addr = 1'b1; #1; n_vec++;
    if (data_out !== 4'b0001) begin n_err++; $display("FAIL status clear: got %b required 0001", data_out); end
    addr = 1'b0;
    repeat (DF - 1) run_frame('0, 0, 0, 0);
    repeat (DF - 1) run_frame(16'h1 << 5, 0, 0, 0);
    run_frame(16'h1 << 5, 1, 0, FC - 1);
    addr = 1'b1; #1; n_vec++;
    if (data_out !== 4'b0011 || key_valid !== 1'b1) begin
      n_err++; $display("FAIL latch+read: status=%b valid=%b required 0011 1", data_out, key_valid);
    end
    addr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    k = $urandom_range(0, 15);
    clean_start();
    repeat (2) run_frame(16'h1 << k, 0, 0, 0);
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    model_reset();
    #1; n_vec++;
    if (cols !== 4'b1110 || key_valid !== 1'b0 || data_out !== 4'h0) begin
      n_err++; $display("FAIL mid reset: cols=%b valid=%b key=%h required 1110 0 0", cols, key_valid, data_out);
    end
    repeat (2) run_frame(16'h1 << k, 0, 0, 0);
    #1; n_vec++;
    if (key_valid !== 1'b0) begin n_err++; $display("FAIL fresh frames: valid=%b required 0", key_valid); end
    run_frame(16'h1 << k, 0, 0, 0);
    #1; n_vec++;
    if (key_valid !== 1'b1 || data_out !== 4'(k)) begin
      n_err++; $display("FAIL post-reset latch: valid=%b key=%h required 1 %h", key_valid, data_out, 4'(k));
    end
    clean_start();
    repeat (DF) run_frame((16'h1 << 6) | (16'h1 << 14), 0, 0, 0);
    #1; n_vec++;
    if (data_out !== 4'b0110) begin n_err++; $display("FAIL two rows: key=%b required 0110", data_out); end
  endtask

  task automatic test_random();
    logic [15:0] m;
    for (int e = 0; e < 30; e++) begin
      m = 16'h1 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) m |= 16'h1 << $urandom_range(0, 15);
      repeat ($urandom_range(1, 5))
        run_frame(m, $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, FC - 1));
      repeat ($urandom_range(1, 4))
        run_frame('0, $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, FC - 1));
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_hold();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/xkeypad_controller.md
Name: xkeypad_controller

Overview:
- Input-side counterpart of the 7-segment display peripheral: a 4x4 matrix keypad scanner for the calculator.
- Drives one active-low column at a time and samples the four active-low rows, with pull-ups on the rows.
- Debounces the samples and latches a 4-bit key code that the CPU reads through the peripheral select/address bus.
- Provides valid and overrun status bits so software can poll for new keys.

Parameters:
- SCAN_DIV, 50000: clock cycles per column dwell. Must be ≥ 2.
- DEBOUNCE_FRAMES, 3: consecutive identical full-scan frames needed to accept a press. The same count of consecutive empty frames is needed to accept a release. Must be ≥ 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- kbd_sel  input  1  CPU access strobe for this peripheral.
- addr  input  1  register select: 0 = key code, 1 = status.
- data_out  output  4  read data.
- rows  input  4  keypad rows, active-low, asynchronous.
- cols  output  4  keypad column drive, active-low one-hot.
- key_valid  output  1  unread key available (mirrors the status bit).

Behaviour:
- Reset values: cols = 4'b1110, key_reg = 0, key_valid = 0, overrun = 0, FSM = IDLE, all counters 0.
  - Reset asserted mid-scan or mid-debounce returns to this state on the next edge.
  - A pending key is lost on reset.
- Row synchronizer: rows pass through a 2-flop synchronizer, giving rows_s. Sampling uses rows_s only.
- Scan timing:
  - Counter runs 0..SCAN_DIV-1, then wraps.
  - tick = (counter == SCAN_DIV-1).
  - On tick, cols rotates left: {cols[2:0], cols[3]}. Columns are visited in the order 0, 1, 2, 3.
  - Column index c = position of the 0 bit in cols.
- Sampling:
  - On tick, rows_s is evaluated against the current column before the rotation takes effect.
  - Hit when any rows_s bit is 0. r = lowest-index 0 bit, so multiple rows pressed means the lowest row wins.
  - code = {r[1:0], c[1:0]}.
- Frame:
  - Four consecutive ticks, columns 0..3. The frame ends on the tick sampling column 3.
  - Frame result = code of the first hit in the frame (lowest column wins), or NONE.
  - The FSM updates only at frame end.
- FSM, evaluated at frame end:
  - IDLE:
    - NONE: stay.
    - Hit: cand = code, dcnt = 1.
    - If DEBOUNCE_FRAMES == 1, latch immediately and go to HELD; otherwise go to DEBOUNCE.
  - DEBOUNCE:
    - Hit == cand: dcnt++. When dcnt reaches DEBOUNCE_FRAMES, latch and go to HELD.
    - Hit != cand: cand = code, dcnt = 1, stay in DEBOUNCE.
    - NONE: go to IDLE, dcnt = 0.
  - HELD:
    - Hit (any code): rcnt = 0, stay. There is no auto-repeat and no second latch while held.
    - NONE: rcnt++. When rcnt reaches DEBOUNCE_FRAMES, go to IDLE.
- Latch action, in the same edge as the FSM transition:
  - key_reg <= cand.
  - key_valid <= 1.
  - If key_valid was already 1, overrun <= 1.
- CPU access:
  - data_out is combinational and independent of kbd_sel.
    - addr = 0: key_reg.
    - addr = 1: {2'b00, overrun, key_valid}.
  - Read side effects happen only when kbd_sel = 1, at the clock edge.
    - addr = 0: key_valid <= 0.
    - addr = 1: overrun <= 0.
  - key_reg is never cleared by a read.
  - A read of the same cycle still returns the pre-edge values.
- Simultaneous events:
  - Latch in the same cycle as a key-code read: set wins, so key_valid = 1 and key_reg = new code. overrun is set because key_valid was 1 before the edge.
  - Latch in the same cycle as a status read: the overrun set wins.
- Counters: dcnt and rcnt are wide enough for DEBOUNCE_FRAMES and saturate; they never wrap.

Test Plan:
1. Reset check (SCAN_DIV = 4, DEBOUNCE_FRAMES = 3), rows = 4'hF:
   - Right after rst, cols = 1110, data_out(addr 0) = 0, status = 0000.
   - cols steps 1110 → 1101 → 1011 → 0111 → 1110 every 4 cycles.
2. Press row 2 while cols = 1011 (col 2), held steady:
   - After 3 full frames, key_valid = 1 and key_reg = 4'b1010.
   - Status read returns 0001.
   - Key-code read returns 1010, then key_valid = 0.
3. Bounce on row 1 / col 0:
   - Stimulus: present 1 frame, absent 1 frame, present 2 frames, released.
   - Required: key_valid never asserts.
   - Then present 3 frames: key_valid = 1, key_reg = 4'b0100.
4. Hold and release:
   - Hold key 0 for 10 frames: exactly one latch.
   - Release for 2 frames, re-press: no new latch.
   - Release for 3 frames, re-press for 3 frames: second latch.
5. Overrun:
   - Latch key 5, do not read, then latch key 9.
   - Required: key_reg = 9, status = 0011.
   - Status read → 0001.
   - Key-code read in the exact cycle of a third latch → key_valid stays 1 and overrun = 1.
6. Reset mid-debounce:
   - Assert rst for 1 cycle after 2 of 3 matching frames.
   - Required: state returns to IDLE, cols = 1110, and a key needs 3 fresh frames to latch.
   - Also check two rows pressed in the same column → the lower row code is reported.
